mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares the single-ported, byte-wide instruction/data memory between the fetch stage and the load/store stage. Each granted request is broken into 1, 2 or 4 sequential byte beats, with bytes assembled or split little-endian. Fetch and data requests are served one at a time, with round-robin priority when both are pending.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between fetch and load/store requesters.
// Each grant becomes 1, 2 or 4 little-endian byte beats; ties alternate round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  localparam logic P_FETCH = 1'b0;
  localparam logic P_DATA  = 1'b1;

  // Request fields frozen at grant; last_beat is N-1.
  typedef struct packed {
    logic              port;
    logic [ADDR_W-1:0] base;
    logic              we;
    logic [1:0]        last_beat;
    logic [31:0]       wdata;
  } xfer_t;

  state_t      state_q, state_d;
  xfer_t       xfer_q, xfer_d;
  logic [1:0]  beat_q, beat_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        gnt;
  logic [31:0] rd_word;
  logic [4:0]  lane_lsb;

  assign lane_lsb = {beat_q, 3'b000};

  always_comb begin
    state_d      = state_q;
    xfer_d       = xfer_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    gnt          = P_FETCH;
    rd_word      = '0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // On a tie, the port that did not win last time goes next.
          if (if_req && d_req) gnt = ~last_grant_q;
          else                 gnt = d_req;
          xfer_d.port = gnt;
          if (gnt == P_DATA) begin
            xfer_d.base  = d_addr;
            xfer_d.we    = d_we;
            xfer_d.wdata = d_wdata;
            case (d_size)
              2'd0:    xfer_d.last_beat = 2'd0;
              2'd1:    xfer_d.last_beat = 2'd1;
              default: xfer_d.last_beat = 2'd3;
            endcase
            d_rdata_d = '0;
          end else begin
            xfer_d.base      = if_addr;
            xfer_d.we        = 1'b0;
            xfer_d.wdata     = '0;
            xfer_d.last_beat = 2'd3;
            if_rdata_d       = '0;
          end
          beat_d  = 2'd0;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (!xfer_q.we) begin
          rd_word = (xfer_q.port == P_DATA) ? d_rdata_q : if_rdata_q;
          rd_word[lane_lsb +: 8] = mem_rdata;
          if (xfer_q.port == P_DATA) d_rdata_d  = rd_word;
          else                       if_rdata_d = rd_word;
        end
        beat_d = beat_q + 2'd1;
        if (beat_q == xfer_q.last_beat) state_d = DONE;
      end
      DONE: begin
        last_grant_d = xfer_q.port;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      xfer_q       <= '0;
      beat_q       <= 2'd0;
      last_grant_q <= P_DATA;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      xfer_q       <= xfer_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Memory-side outputs decode straight from state so reset silences them at once.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (state_q == BEAT) begin
      mem_addr = xfer_q.base + {{(ADDR_W-2){1'b0}}, beat_q};
      if (xfer_q.we) begin
        mem_we    = 1'b1;
        mem_wdata = xfer_q.wdata[lane_lsb +: 8];
      end
    end
  end

  assign if_ready = (state_q == DONE) && (xfer_q.port == P_FETCH);
  assign d_ready  = (state_q == DONE) && (xfer_q.port == P_DATA);
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 4 KiB byte memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [11:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = '0;
  logic [11:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0] mem [4096];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits at falling edges for the chosen port's ready; lat = -1 on timeout.
  task automatic wait_ready(input bit port, input int c0, output int lat);
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (port ? d_ready : if_ready) begin
        lat = cyc - c0;
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready got %b exp 0", if_ready); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready got %b exp 0", d_ready); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata got %h exp 0", if_rdata); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata got %h exp 0", d_rdata); end
    checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    do_reset();
  endtask

  task automatic test_fetch();
    int c0, lat;
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
    if_addr = 12'h000; if_req = 1'b1; c0 = cyc;
    wait_ready(1'b0, c0, lat);
    if_req = 1'b0;
    checks++; if (lat !== 5) begin errors++; $display("FAIL fetch_latency got %0d exp 5", lat); end
    checks++; if (if_rdata !== 32'h00000513) begin errors++; $display("FAIL fetch_rdata got %h exp 00000513", if_rdata); end
    step();
  endtask

  task automatic test_tie();
    int c0, lat;
    do_reset();
    mem[8] = 8'h11; mem[9] = 8'h22; mem[10] = 8'h33; mem[11] = 8'h44;
    if_addr = 12'h000; if_req = 1'b1;
    d_addr = 12'h008; d_we = 1'b0; d_size = 2'd2; d_req = 1'b1;
    c0 = cyc;
    wait_ready(1'b0, c0, lat);
    if_req = 1'b0;
    checks++; if (lat !== 5) begin errors++; $display("FAIL tie_fetch_latency got %0d exp 5", lat); end
    checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL tie_d_ready_early got %b exp 0", d_ready); end
    wait_ready(1'b1, c0, lat);
    d_req = 1'b0;
    checks++; if (lat !== 11) begin errors++; $display("FAIL tie_data_latency got %0d exp 11", lat); end
    checks++; if (d_rdata !== 32'h44332211) begin errors++; $display("FAIL tie_data_rdata got %h exp 44332211", d_rdata); end
    step();
  endtask

  task automatic test_store_half();
    int c0, lat;
    mem[12'h101] = 8'h11; mem[12'h102] = 8'h22; mem[12'h103] = 8'h33;
    d_addr = 12'h101; d_wdata = 32'hAABBCCDD; d_we = 1'b1; d_size = 2'd1; d_req = 1'b1;
    c0 = cyc;
    wait_ready(1'b1, c0, lat);
    d_req = 1'b0;
    checks++; if (lat !== 3) begin errors++; $display("FAIL store_half_latency got %0d exp 3", lat); end
    checks++; if (mem[12'h101] !== 8'hDD) begin errors++; $display("FAIL store_half_b0 got %h exp DD", mem[12'h101]); end
    checks++; if (mem[12'h102] !== 8'hCC) begin errors++; $display("FAIL store_half_b1 got %h exp CC", mem[12'h102]); end
    checks++; if (mem[12'h103] !== 8'h33) begin errors++; $display("FAIL store_half_b2 got %h exp 33", mem[12'h103]); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata got %h exp 0", d_rdata); end
    step();
    d_addr = 12'h102; d_we = 1'b0; d_size = 2'd0; d_wdata = 32'hFFFFFFFF; d_req = 1'b1;
    c0 = cyc;
    wait_ready(1'b1, c0, lat);
    d_req = 1'b0;
    checks++; if (lat !== 2) begin errors++; $display("FAIL load_byte_latency got %0d exp 2", lat); end
    checks++; if (d_rdata !== 32'h000000CC) begin errors++; $display("FAIL load_byte_rdata got %h exp 000000CC", d_rdata); end
    step();
  endtask

  task automatic test_wrap();
    logic [11:0] exp_addr [4];
    logic [11:0] got;
    exp_addr[0] = 12'hFFE; exp_addr[1] = 12'hFFF; exp_addr[2] = 12'h000; exp_addr[3] = 12'h001;
    mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hB2; mem[0] = 8'hC3; mem[1] = 8'hD4;
    if_addr = 12'hFFE; if_req = 1'b1;
    @(negedge clk);
    checks++; if (mem_addr !== 12'h000) begin errors++; $display("FAIL wrap_idle_addr got %h exp 000", mem_addr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      got = mem_addr;
      checks++; if (got !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr%0d got %h exp %h", i, got, exp_addr[i]); end
    end
    @(negedge clk);
    if_req = 1'b0;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready got %b exp 1", if_ready); end
    checks++; if (if_rdata !== 32'hD4C3B2A1) begin errors++; $display("FAIL wrap_rdata got %h exp D4C3B2A1", if_rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    for (int i = 0; i < 4; i++) mem[12'h40 + i] = 8'h00;
    d_addr = 12'h040; d_wdata = 32'h44332211; d_we = 1'b1; d_size = 2'd2; d_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (d_ready) seen++;
    end
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL rstmid_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 8'h0) begin errors++; $display("FAIL rstmid_mem_wdata got %h exp 0", mem_wdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (d_ready) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d_ready) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_ready got %0d pulses exp 0", seen); end
    checks++; if (mem[12'h40] !== 8'h11) begin errors++; $display("FAIL rstmid_b0 got %h exp 11", mem[12'h40]); end
    checks++; if (mem[12'h41] !== 8'h22) begin errors++; $display("FAIL rstmid_b1 got %h exp 22", mem[12'h41]); end
    checks++; if (mem[12'h42] !== 8'h00) begin errors++; $display("FAIL rstmid_b2 got %h exp 00", mem[12'h42]); end
    checks++; if (mem[12'h43] !== 8'h00) begin errors++; $display("FAIL rstmid_b3 got %h exp 00", mem[12'h43]); end
    step();
  endtask

  task automatic test_back_to_back();
    bit order [4];
    bit exp_order [4];
    int n, wide;
    bit prev_if, prev_d;
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
    n = 0; wide = 0; prev_if = 1'b0; prev_d = 1'b0;
    do_reset();
    if_addr = 12'h010; if_req = 1'b1;
    d_addr = 12'h020; d_we = 1'b0; d_size = 2'd0; d_req = 1'b1;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (if_ready && d_ready) wide++;
      if ((if_ready && prev_if) || (d_ready && prev_d)) wide++;
      if (if_ready && !prev_if) begin order[n] = 1'b0; n++; end
      else if (d_ready && !prev_d) begin order[n] = 1'b1; n++; end
      prev_if = if_ready; prev_d = d_ready;
    end
    @(negedge clk);
    if ((if_ready && prev_if) || (d_ready && prev_d)) wide++;
    if_req = 1'b0; d_req = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", n); end
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        checks++; if (order[i] !== exp_order[i]) begin errors++; $display("FAIL b2b_order%0d got %0d exp %0d", i, order[i], exp_order[i]); end
      end
    end
    checks++; if (wide !== 0) begin errors++; $display("FAIL b2b_ready_width got %0d violations exp 0", wide); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    test_reset();
    test_fetch();
    test_tie();
    test_store_half();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
